// File: rtl/vs_mux_if.sv
// Select/data bundle shared by the 2:1 and 4:1 mux paths, plus their
// combinational and registered results.
interface vs_mux_if #(
  parameter int WIDTH = 4
);
  logic             sel_1bit;
  logic [1:0]       sel_2bit;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y4;
  logic [WIDTH-1:0] y2_q;
  logic [WIDTH-1:0] y4_q;

  modport master (
    output sel_1bit, sel_2bit, in0, in1, in2, in3,
    input  y2, y4, y2_q, y4_q
  );

  modport slave (
    input  sel_1bit, sel_2bit, in0, in1, in2, in3,
    output y2, y4, y2_q, y4_q
  );
endinterface

// File: rtl/vs_mux.sv
// 2:1 and 4:1 multiplexers over shared data inputs, with an optional
// one-cycle registered copy of each result.
module vs_mux #(
  parameter int WIDTH   = 4,
  parameter bit REG_OUT = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  vs_mux_if.slave bus
);

  logic [WIDTH-1:0] w_y2;
  logic [WIDTH-1:0] w_y4;

  // Unknown selects fall to the default arm, so simulation shows zero
  // instead of propagating X; synthesis sees a fully decoded case.
  always_comb begin
    w_y2 = '0;
    case (bus.sel_1bit)
      1'b0:    w_y2 = bus.in0;
      1'b1:    w_y2 = bus.in1;
      default: w_y2 = '0;
    endcase
  end

  always_comb begin
    w_y4 = '0;
    case (bus.sel_2bit)
      2'd0:    w_y4 = bus.in0;
      2'd1:    w_y4 = bus.in1;
      2'd2:    w_y4 = bus.in2;
      2'd3:    w_y4 = bus.in3;
      default: w_y4 = '0;
    endcase
  end

  assign bus.y2 = w_y2;
  assign bus.y4 = w_y4;

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] r_y2_q;
      logic [WIDTH-1:0] r_y4_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_y2_q <= '0;
          r_y4_q <= '0;
        end else begin
          r_y2_q <= w_y2;
          r_y4_q <= w_y4;
        end
      end

      assign bus.y2_q = r_y2_q;
      assign bus.y4_q = r_y4_q;
    end else begin : g_comb
      // Clock and reset are deliberately unused in the pass-through build.
      logic w_unused_clkrst;
      assign w_unused_clkrst = clk ^ rst_n;
      assign bus.y2_q = w_y2;
      assign bus.y4_q = w_y4;
    end
  endgenerate

endmodule

// File: tb/tb_vs_mux.sv
// Scoreboard bench: one registered and one pass-through vs_mux share the
// same stimulus; expected values come from an array-indexing model.
module tb_vs_mux;

  logic clk;
  logic rst_n;

  vs_mux_if #(.WIDTH(4)) busReg ();
  vs_mux_if #(.WIDTH(4)) busComb ();

  vs_mux #(.WIDTH(4), .REG_OUT(1'b1)) dutReg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busReg.slave)
  );

  vs_mux #(.WIDTH(4), .REG_OUT(1'b0)) dutComb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busComb.slave)
  );

  typedef struct {
    int         stepId;
    logic [3:0] y2;
    logic [3:0] y4;
    logic [3:0] y2q;
    logic [3:0] y4q;
  } expT;

  expT        expQ[$];
  event       sampleEv;
  int         checks   = 0;
  int         failures = 0;
  int         stepNum  = 0;

  logic [3:0] inArr [4];
  logic       sel1Cur;
  logic [1:0] sel2Cur;
  logic [3:0] modelY2q;
  logic [3:0] modelY4q;

  task automatic compare(input int stepId, input string what,
                         input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL step%0d/%s actual=%0d expected=%0d", stepId, what, act, want);
    end
  endtask

  // Monitor: pops the oldest expectation whenever a sample is announced.
  initial begin
    expT e;
    forever begin
      @(sampleEv);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
      end else begin
        e = expQ.pop_front();
        compare(e.stepId, "reg.y2",   busReg.y2,    e.y2);
        compare(e.stepId, "reg.y4",   busReg.y4,    e.y4);
        compare(e.stepId, "reg.y2_q", busReg.y2_q,  e.y2q);
        compare(e.stepId, "reg.y4_q", busReg.y4_q,  e.y4q);
        compare(e.stepId, "comb.y2",   busComb.y2,   e.y2);
        compare(e.stepId, "comb.y4",   busComb.y4,   e.y4);
        compare(e.stepId, "comb.y2_q", busComb.y2_q, e.y2);
        compare(e.stepId, "comb.y4_q", busComb.y4_q, e.y4);
      end
    end
  end

  task automatic applyStimulus(input logic s1, input logic [1:0] s2,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
    sel1Cur  = s1;
    sel2Cur  = s2;
    inArr[0] = a;
    inArr[1] = b;
    inArr[2] = c;
    inArr[3] = d;
    busReg.sel_1bit  = s1;  busComb.sel_1bit = s1;
    busReg.sel_2bit  = s2;  busComb.sel_2bit = s2;
    busReg.in0 = a;  busComb.in0 = a;
    busReg.in1 = b;  busComb.in1 = b;
    busReg.in2 = c;  busComb.in2 = c;
    busReg.in3 = d;  busComb.in3 = d;
  endtask

  task automatic checkOutput();
    expT e;
    #1;
    e.stepId = stepNum++;
    e.y2     = inArr[int'(sel1Cur)];
    e.y4     = inArr[int'(sel2Cur)];
    e.y2q    = modelY2q;
    e.y4q    = modelY4q;
    expQ.push_back(e);
    ->sampleEv;
    #1;
  endtask

  // One full clock period; the model captures the selections at the edge.
  task automatic tick();
    #2 clk = 1'b1;
    if (rst_n) begin
      modelY2q = inArr[int'(sel1Cur)];
      modelY4q = inArr[int'(sel2Cur)];
    end
    #5 clk = 1'b0;
    #3;
  endtask

  task automatic setReset(input logic value);
    rst_n = value;
    if (!value) begin
      modelY2q = '0;
      modelY4q = '0;
    end
  endtask

  initial begin
    clk      = 1'b0;
    modelY2q = '0;
    modelY4q = '0;
    setReset(1'b0);
    applyStimulus(1'b0, 2'd0, 4'd2, 4'd4, 4'd6, 4'd8);
    checkOutput();

    // Combinational outputs follow inputs during reset and with a static clock.
    applyStimulus(1'b1, 2'd0, 4'd2, 4'd4, 4'd6, 4'd8);
    checkOutput();
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b0, 2'(s), 4'd2, 4'd4, 4'd6, 4'd8);
      checkOutput();
    end

    setReset(1'b1);
    checkOutput();
    applyStimulus(1'b1, 2'd2, 4'd2, 4'd4, 4'd6, 4'd8);
    tick();
    checkOutput();
    applyStimulus(1'b1, 2'd3, 4'd2, 4'd4, 4'd6, 4'd8);
    checkOutput();
    tick();
    checkOutput();

    // Mid-operation reset clears registered outputs without an edge.
    setReset(1'b0);
    checkOutput();
    setReset(1'b1);
    checkOutput();
    tick();
    checkOutput();

    for (int v = 0; v < 16; v++) begin
      applyStimulus(1'b1, 2'd3, 4'd2, 4'd4, 4'(v), 4'(15 - v));
      checkOutput();
      tick();
      checkOutput();
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom));
      if ($urandom_range(0, 15) == 0) begin
        setReset(1'b0);
        checkOutput();
        if ($urandom_range(0, 1) == 1) tick();
        checkOutput();
        setReset(1'b1);
        checkOutput();
      end else begin
        checkOutput();
        if ($urandom_range(0, 3) != 0) tick();
        checkOutput();
      end
    end

    #5;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vs_mux.md
VS_MUX -- requirements
Module: vs_mux

Interface
REQ-001 Parameter WIDTH, default 4, sets the bit width of every data input and data output; legal range 1..64.
REQ-002 Parameter REG_OUT, default 1, where 1 instantiates the registered output stage and 0 ties each registered output to its combinational counterpart.
REQ-003 clk  input  1  sole clock; every register samples on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 sel_1bit  input  1  select for the 2:1 path.
REQ-006 sel_2bit  input  2  select for the 4:1 path.
REQ-007 in0, in1, in2, in3  input  WIDTH each  data inputs, shared by both paths.
REQ-008 y2  output  WIDTH  combinational 2:1 result.
REQ-009 y4  output  WIDTH  combinational 4:1 result.
REQ-010 y2_q  output  WIDTH  registered copy of y2.
REQ-011 y4_q  output  WIDTH  registered copy of y4.

Function
REQ-012 y2 SHALL equal in0 when sel_1bit=0 and in1 when sel_1bit=1, with zero-cycle (purely combinational) latency.
REQ-013 y4 SHALL equal in0, in1, in2 or in3 for sel_2bit = 0, 1, 2 or 3 respectively, with zero-cycle latency.
REQ-014 in2 and in3 SHALL have no effect on y2 or y2_q.
REQ-015 y2 SHALL be all-zero when sel_1bit is X or Z, and y4 SHALL be all-zero when any bit of sel_2bit is X or Z; simulation only, with no synthesis impact.
REQ-016 Each output SHALL pass its selected input through bit-exact, with no arithmetic, extension or truncation.
REQ-017 When REG_OUT=1, y2_q and y4_q SHALL load y2 and y4 on every rising clk edge while rst_n=1, giving exactly one cycle of latency.
REQ-018 The registered outputs SHALL have no enable and no handshake; they SHALL update on every cycle.
REQ-019 When REG_OUT=0, y2_q SHALL equal y2 and y4_q SHALL equal y4 combinationally, and rst_n SHALL have no effect.
REQ-020 A change of select and data inside the same cycle SHALL appear on y2/y4 immediately and on y2_q/y4_q at the next rising edge.
REQ-021 The combinational path SHALL contain no latches, and y2/y4 SHALL NOT depend on clk or rst_n.

Reset
REQ-022 While rst_n=0, y2_q and y4_q SHALL be all-zero, and assertion of rst_n SHALL take effect immediately, independent of clk.
REQ-023 Reset SHALL NOT affect y2 or y4, which keep following their inputs during reset.
REQ-024 Reset asserted mid-operation SHALL clear the registered outputs at once.
REQ-025 After rst_n deasserts, the first rising clk edge SHALL load current y2/y4 into y2_q/y4_q.
REQ-026 Deassertion of rst_n is synchronous to clk, and the block SHALL require no other initialisation.

Verification
REQ-027 Set in0..in3 = 2,4,6,8 (WIDTH=4) and sel_1bit=0 -> y2=2; then sel_1bit=1 -> y2=4, both within the same delta and without a clock edge.
REQ-028 With the same inputs, sweep sel_2bit 0,1,2,3 -> y4 = 2,4,6,8 respectively.
REQ-029 With REG_OUT=1, apply sel_2bit=2 then one rising edge -> y4_q=6; change sel_2bit to 3 -> y4=8 immediately, while y4_q stays 6 until the next edge, then becomes 8.
REQ-030 Drive rst_n=0 between clock edges while y2_q=4 and y4_q=8 -> both go to 0 at once while y2/y4 are unchanged; release rst_n -> the first edge restores y2_q=4 and y4_q=8.
REQ-031 Toggle in2 and in3 through all 16 values with sel_1bit fixed -> y2 and y2_q never change.
REQ-032 With REG_OUT=0 and clk held static, sweep the selects -> y2_q/y4_q track y2/y4 exactly, and holding rst_n=0 has no effect.
